// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle main-control FSM producing datapath enables and aluop
//
// Purpose: sequences fetch/decode/execute/memory/writeback for the 5-bit-opcode CPU.
//   Outputs are decoded from the state register only. The exceptions are irwrite/pcwrite
//   in FETCH, which follow mem_ready, and pcwrite in BRANCH, which follows zero.
// Optional feature macro: MC_PERF_CNT_EN (adds COUNT_W parameter and instr_count output).
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   op [OP_W-1:0]       opcode from instruction register, sampled in DECODE
//   zero                ALU zero flag (BRANCH)
//   mem_ready           memory handshake (FETCH, MEMREAD, MEMWRITE)
//   aluop [1:0]         00 add, 01 sub, 10 R-type, 11 immediate
//   alusrca [1:0]       00 PC, 01 oldPC, 10 regA
//   alusrcb [1:0]       00 regB, 01 imm, 10 const 1
//   resultsrc [1:0]     00 ALUOut, 01 memdata, 10 ALU result
//   adrsrc              0 PC, 1 ALUOut
//   irwrite, pcwrite, regwrite, memwrite   datapath strobes
//   state [3:0]         current state (debug)
//   instr_count         retired-instruction counter (MC_PERF_CNT_EN only)
module multicycle_ctrl #(
   parameter int OP_W = 5
`ifdef MC_PERF_CNT_EN
   , parameter int COUNT_W = 32
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OP_W-1:0] op,
   input  logic            zero,
   input  logic            mem_ready,
   output logic [1:0]      aluop,
   output logic [1:0]      alusrca,
   output logic [1:0]      alusrcb,
   output logic [1:0]      resultsrc,
   output logic            adrsrc,
   output logic            irwrite,
   output logic            pcwrite,
   output logic            regwrite,
   output logic            memwrite,
   output logic [3:0]      state
`ifdef MC_PERF_CNT_EN
   , output logic [COUNT_W-1:0] instr_count
`endif
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10
   } state_t;

   state_t          state_q, state_d;
   logic [OP_W-1:0] op_q, op_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      aluop     = 2'b00;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      resultsrc = 2'b00;
      adrsrc    = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            if (mem_ready) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            // ALU precomputes oldPC + imm as the branch/jump target.
            alusrca = 2'b01;
            alusrcb = 2'b01;
            op_d    = op;
            if (op[4:3] == 2'b00)                        state_d = S_EXECR;
            else if (op == 5'b01000 || op == 5'b01001)   state_d = S_MEMADR;
            else if (op == 5'b01010)                     state_d = S_BRANCH;
            else if (op == 5'b01011)                     state_d = S_JUMP;
            else if (op[4:2] == 3'b011)                  state_d = S_EXECI;
            else                                         state_d = S_FETCH;
         end
         S_MEMADR: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            // Only LW/SW reach MEMADR, so the latched opcode's LSB selects the branch.
            state_d = (op_q == 5'b01000) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adrsrc = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            resultsrc = 2'b01;
            regwrite  = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            alusrca = 2'b10;
            aluop   = 2'b10;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            aluop   = 2'b11;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            alusrca = 2'b10;
            aluop   = 2'b01;
            pcwrite = zero;
            state_d = S_FETCH;
         end
         S_JUMP: begin
            alusrca   = 2'b01;
            alusrcb   = 2'b01;
            resultsrc = 2'b10;
            pcwrite   = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign state = state_q;

`ifdef MC_PERF_CNT_EN
   logic [COUNT_W-1:0] count_q, count_d;

   // An instruction retires whenever the FSM returns to FETCH from elsewhere.
   always_comb begin
      count_d = count_q;
      if (state_q != S_FETCH && state_d == S_FETCH)
         count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign instr_count = count_q;
`endif

endmodule
